// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Boot-time program loader for the 16-bit CPU's instruction memory.
// Receives a byte stream over a valid/ready handshake, assembles big-endian
// 16-bit words and writes them sequentially into the instruction memory
// starting at address 0. The CPU is held in reset until the full image has
// been written and the final write has committed.
//
// Stream format: LEN_HI, LEN_LO (word count N), then 2N data bytes with the
// high byte first, then an optional checksum byte.
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
//   defined   : a trailing checksum byte (XOR of all preceding bytes,
//               length bytes included) is expected; a mismatch rejects
//               the load.
//   undefined : no checksum byte, no XOR register; the only error source
//               is a length larger than the memory.
//
// Parameters:
//   ADDR_W        instruction memory address width (2^ADDR_W words)
//
// Ports:
//   clock         system clock, rising edge
//   reset_n       synchronous active-low reset
//   in_data       stream byte
//   in_valid      in_data is valid
//   in_ready      loader accepts a byte this cycle
//   imem_we       instruction memory write enable, one-cycle pulse per word
//   imem_addr     instruction memory write address
//   imem_wdata    instruction memory write data {hi, lo}
//   cpu_rst_n     CPU reset, low until the load completes
//   done          image loaded, CPU released
//   error         load rejected, CPU stays in reset
//   words_loaded  number of words written so far
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_HI  = 3'd0,
    S_LEN_LO  = 3'd1,
    S_DATA_HI = 3'd2,
    S_DATA_LO = 3'd3,
    S_CHK     = 3'd4,
    S_FLUSH   = 3'd5,
    S_RUN     = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  // Where the FSM goes once the last word (or an empty image) is in.
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CHK;
`else
  localparam state_t S_AFTER_DATA = S_FLUSH;
`endif

  localparam logic [ADDR_W:0] ONE_W    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [16:0]     CAPACITY = 17'd1 << ADDR_W;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_ready;
  logic                w_ready_next;
  logic                w_accept;

  logic [15:0]         r_len;
  logic [7:0]          r_hi;
  logic [ADDR_W:0]     r_words;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_wdata;

  logic [16:0]         w_len_new;
  logic                w_len_over;
  logic                w_last_word;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          r_xor;
  logic                w_chk_ok;
`endif

  // ---------------------------------------------------------------------------
  // Handshake and decode helpers
  // ---------------------------------------------------------------------------
  assign w_accept = in_valid && r_ready;

  // Full length as it will be once LEN_LO is latched; 17 bits so that the
  // comparison against 2^ADDR_W cannot overflow for any ADDR_W up to 16.
  assign w_len_new  = {1'b0, r_len[15:8], in_data};
  assign w_len_over = (w_len_new > CAPACITY);

  // The word currently being completed is word N.
  assign w_last_word = ((17'(r_words) + 17'd1) == {1'b0, r_len});

`ifdef PROG_LOADER_CHECKSUM_EN
  assign w_chk_ok = (in_data == r_xor);
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // in_ready is registered from the next state so that it is 0 throughout
  // reset and rises one edge after reset_n is released, with no
  // combinational path from reset_n or in_valid to in_ready.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_LEN_HI;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ready <= w_ready_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LEN_HI: begin
        if (w_accept) w_state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_accept) begin
          if (w_len_over)              w_state_next = S_ERR;
          else if (w_len_new == 17'd0) w_state_next = S_AFTER_DATA;
          else                         w_state_next = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (w_accept) w_state_next = S_DATA_LO;
      end
      S_DATA_LO: begin
        if (w_accept) w_state_next = w_last_word ? S_AFTER_DATA : S_DATA_HI;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_accept) w_state_next = w_chk_ok ? S_FLUSH : S_ERR;
      end
`endif
      // One dead cycle so the final imem write commits before the CPU runs.
      S_FLUSH: w_state_next = S_RUN;
      default: w_state_next = r_state;   // S_RUN / S_ERR are terminal
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ready_next = 1'b0;
    case (w_state_next)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: w_ready_next = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK:                                    w_ready_next = 1'b1;
`endif
      default:                                  w_ready_next = 1'b0;
    endcase
  end

  assign in_ready  = r_ready;
  assign done      = (r_state == S_RUN);
  assign error     = (r_state == S_ERR);
  assign cpu_rst_n = done;

  // ---------------------------------------------------------------------------
  // Datapath: length, high-byte latch, word counter and write port registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_len   <= 16'd0;
      r_hi    <= 8'd0;
      r_words <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 16'd0;
    end else begin
      r_we <= 1'b0;   // write enable is a single-cycle pulse
      if (w_accept) begin
        case (r_state)
          S_LEN_HI:  r_len[15:8] <= in_data;
          S_LEN_LO:  r_len[7:0]  <= in_data;
          S_DATA_HI: r_hi        <= in_data;
          S_DATA_LO: begin
            r_we    <= 1'b1;
            // Address is the pre-increment count; it only wraps to 0
            // after word 2^ADDR_W, which is necessarily the last one.
            r_addr  <= r_words[ADDR_W-1:0];
            r_wdata <= {r_hi, in_data};
            r_words <= r_words + ONE_W;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  // Running XOR of every byte before the checksum byte.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_xor <= 8'd0;
    end else if (w_accept && (r_state != S_CHK)) begin
      r_xor <= r_xor ^ in_data;
    end
  end
`endif

  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Directed bench for prog_loader with ADDR_W=2 (4-word memory) so the exact
// fill and overflow boundaries are reachable. A table of load scenarios is
// applied in a loop; a hand-written sequence covers reset in mid-load.
// A monitor records every imem write seen; expected writes come from the
// table. The checksum byte is appended when PROG_LOADER_CHECKSUM_EN is set.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  localparam int AW = 2;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          cpu_rst_n;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  prog_loader #(.ADDR_W(AW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst_n    (cpu_rst_n),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Write monitor, sampled mid-cycle.
  logic [AW-1:0] wr_addr_q[$];
  logic [15:0]   wr_data_q[$];
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
  end

  typedef struct {
    string            name;
    logic [15:0]      n;          // length field sent
    int               nw;         // data words actually sent
    logic [3:0][15:0] w;          // data words, w[0] first
    int               gap;        // idle cycles between bytes
    bit               bad_chk;    // send FF instead of the true checksum
    bit               exp_done;
    bit               exp_err;
    int               exp_words;
    int               exp_writes;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),     32'd0);
    check({tag, "_imem_we"},   32'(imem_we),      32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr),    32'd0);
    check({tag, "_imem_wdata"},32'(imem_wdata),   32'd0);
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n),    32'd0);
    check({tag, "_done"},      32'(done),         32'd0);
    check({tag, "_error"},     32'(error),        32'd0);
    check({tag, "_words"},     32'(words_loaded), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    @(posedge clock); #1;
    check_reset_vals(tag);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check({tag, "_ready_after_rst"}, 32'(in_ready), 32'd1);
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Present a byte until accepted (bounded), then idle for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok       = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      if (in_ready === 1'b1) begin
        @(posedge clock); #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout byte=%0h actual=not_accepted required=accepted", b);
    end
    if (gap > 0) begin
      repeat (gap) @(posedge clock);
      #1;
    end
  endtask

  task automatic send_stream(input logic [7:0] bytes[$], input int gap);
    for (int i = 0; i < bytes.size(); i++)
      send_byte(bytes[i], (i == bytes.size() - 1) ? 0 : gap);
  endtask

  initial begin
    logic [7:0] bytes[$];
    logic [7:0] x;
    vec_t       v;

    vecs[0] = '{"basic",   16'd2,     2, {16'h0, 16'h0, 16'hABCD, 16'h1234}, 0, 1'b0, 1'b1, 1'b0, 2, 2};
    vecs[1] = '{"gaps",    16'd2,     2, {16'h0, 16'h0, 16'hABCD, 16'h1234}, 3, 1'b0, 1'b1, 1'b0, 2, 2};
    vecs[2] = '{"full",    16'd4,     4, {16'h7788, 16'h5566, 16'h3344, 16'h1122}, 0, 1'b0, 1'b1, 1'b0, 4, 4};
    vecs[3] = '{"over5",   16'd5,     0, {16'h0, 16'h0, 16'h0, 16'h0}, 0, 1'b0, 1'b0, 1'b1, 0, 0};
    vecs[4] = '{"over16b", 16'h0104,  0, {16'h0, 16'h0, 16'h0, 16'h0}, 1, 1'b0, 1'b0, 1'b1, 0, 0};
    vecs[5] = '{"zero",    16'd0,     0, {16'h0, 16'h0, 16'h0, 16'h0}, 0, 1'b0, 1'b1, 1'b0, 0, 0};
    vecs[6] = '{"badchk",  16'd1,     1, {16'h0, 16'h0, 16'h0, 16'h0001}, 0, 1'b1, !CK, CK, 1, 1};

    for (int k = 0; k < 7; k++) begin
      v = vecs[k];
      do_reset({v.name, "_rst"});

      bytes.delete();
      bytes.push_back(v.n[15:8]);
      bytes.push_back(v.n[7:0]);
      for (int i = 0; i < v.nw; i++) begin
        bytes.push_back(v.w[i][15:8]);
        bytes.push_back(v.w[i][7:0]);
      end
      if (CK && v.n <= 16'd4) begin
        x = 8'd0;
        foreach (bytes[i]) x = x ^ bytes[i];
        bytes.push_back(v.bad_chk ? 8'hFF : x);
      end
      send_stream(bytes, v.gap);

      // One edge after the final byte.
      if (v.exp_err) begin
        check({v.name, "_error"},     32'(error),     32'd1);
        check({v.name, "_in_ready"},  32'(in_ready),  32'd0);
        check({v.name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        @(posedge clock); #1;
        check({v.name, "_done_err"},  32'(done),      32'd0);
      end else begin
        check({v.name, "_done_early"},32'(done),      32'd0);
        @(posedge clock); #1;
        check({v.name, "_done"},      32'(done),      32'd1);
        check({v.name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
        check({v.name, "_error"},     32'(error),     32'd0);
        check({v.name, "_in_ready"},  32'(in_ready),  32'd0);
      end
      check({v.name, "_words"},  32'(words_loaded), 32'(v.exp_words));
      check({v.name, "_nwrites"}, 32'(wr_data_q.size()), 32'(v.exp_writes));
      for (int i = 0; i < v.exp_writes && i < wr_data_q.size(); i++) begin
        check($sformatf("%s_addr%0d", v.name, i), 32'(wr_addr_q[i]), 32'(i));
        check($sformatf("%s_data%0d", v.name, i), 32'(wr_data_q[i]), 32'(v.w[i]));
      end

      // Terminal state ignores further input.
      in_data  = 8'h5A;
      in_valid = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      in_valid = 1'b0;
      check({v.name, "_term_writes"}, 32'(wr_data_q.size()), 32'(v.exp_writes));
      check({v.name, "_term_done"},   32'(done),  32'(v.exp_done));
      check({v.name, "_term_error"},  32'(error), 32'(v.exp_err));
      check({v.name, "_term_words"},  32'(words_loaded), 32'(v.exp_words));
    end

    // Reset in mid-load after 3 data bytes of an N=2 image.
    do_reset("mid_rst0");
    bytes.delete();
    bytes = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    send_stream(bytes, 0);
    check("mid_words_before", 32'(words_loaded), 32'd1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    check_reset_vals("mid_rst");
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("mid_ready", 32'(in_ready), 32'd1);
    wr_addr_q.delete();
    wr_data_q.delete();
    bytes.delete();
    bytes = '{8'h00, 8'h02, 8'h55, 8'h66, 8'h77, 8'h88};
    if (CK) bytes.push_back(8'h00 ^ 8'h02 ^ 8'h55 ^ 8'h66 ^ 8'h77 ^ 8'h88);
    send_stream(bytes, 0);
    @(posedge clock); #1;
    check("mid_done",    32'(done),              32'd1);
    check("mid_words",   32'(words_loaded),      32'd2);
    check("mid_nwrites", 32'(wr_data_q.size()),  32'd2);
    if (wr_data_q.size() == 2) begin
      check("mid_addr0", 32'(wr_addr_q[0]), 32'd0);
      check("mid_data0", 32'(wr_data_q[0]), 32'h5566);
      check("mid_addr1", 32'(wr_addr_q[1]), 32'd1);
      check("mid_data1", 32'(wr_data_q[1]), 32'h7788);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
